// File: rtl/emboss_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : emboss_line_buffer
// Purpose  : Raster-to-column converter; buffers two lines and emits (y-2,y-1,y)
// Revision : 1.0 - initial release
// ============================================================================
module emboss_line_buffer #(
    parameter int LINE_WIDTH = 512,
    parameter int COL_W      = 12
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_pixel,
    input  logic       i_pixel_valid,
    input  logic       i_sof,
    output logic       o_pixel_ack,
    output logic [7:0] o_pixel_1,
    output logic [7:0] o_pixel_2,
    output logic [7:0] o_pixel_3,
    output logic       o_pixel_valid,
    input  logic       i_pixel_ack
);

    localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    localparam logic [1:0] S_FILL0  = 2'd0;
    localparam logic [1:0] S_FILL1  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [7:0]       r_line_a [LINE_WIDTH];
    logic [7:0]       r_line_b [LINE_WIDTH];
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_state;

    logic             w_accept;
    logic [COL_W-1:0] w_c;
    logic [AW-1:0]    w_addr;
    logic             w_last;
    logic [1:0]       w_state_cur;
    logic [1:0]       w_state_nxt;
    logic             w_emit;
    logic [7:0]       w_rd_a;
    logic [7:0]       w_rd_b;

    assign o_pixel_ack = ~o_pixel_valid | i_pixel_ack;
    assign w_accept    = i_pixel_valid & o_pixel_ack;

    // A start-of-frame pixel restarts the frame at column 0 in the FILL0 state.
    assign w_c         = i_sof ? '0 : r_col;
    assign w_addr      = w_c[AW-1:0];
    assign w_last      = (w_c == COL_W'(LINE_WIDTH - 1));
    assign w_state_cur = i_sof ? S_FILL0 : r_state;
    assign w_emit      = w_accept & (w_state_cur == S_STREAM);

    assign w_rd_a = r_line_a[w_addr];
    assign w_rd_b = r_line_b[w_addr];

    always_comb begin
        w_state_nxt = w_state_cur;
        if (w_last) begin
            case (w_state_cur)
                S_FILL0:  w_state_nxt = S_FILL1;
                S_FILL1:  w_state_nxt = S_STREAM;
                default:  w_state_nxt = S_STREAM;
            endcase
        end
    end

    // Line memories are never reset: the FILL states mask stale contents.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_line_b[w_addr] <= w_rd_a;
            r_line_a[w_addr] <= i_pixel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col   <= '0;
            r_state <= S_FILL0;
        end else if (w_accept) begin
            r_col   <= w_last ? '0 : w_c + 1'b1;
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pixel_valid <= 1'b0;
            o_pixel_1     <= 8'd0;
            o_pixel_2     <= 8'd0;
            o_pixel_3     <= 8'd0;
        end else if (w_emit) begin
            o_pixel_valid <= 1'b1;
            o_pixel_1     <= w_rd_b;
            o_pixel_2     <= w_rd_a;
            o_pixel_3     <= i_pixel;
        end else if (i_pixel_ack) begin
            o_pixel_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_emboss_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_emboss_line_buffer
// Purpose  : Directed bench for emboss_line_buffer with an image-level column model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_emboss_line_buffer;

    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_pixel;
    logic       i_pixel_valid;
    logic       i_sof;
    logic       o_pixel_ack;
    logic [7:0] o_pixel_1;
    logic [7:0] o_pixel_2;
    logic [7:0] o_pixel_3;
    logic       o_pixel_valid;
    logic       i_pixel_ack;

    always #5 clk = ~clk;

    emboss_line_buffer #(.LINE_WIDTH(LW), .COL_W(12)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_pixel       (i_pixel),
        .i_pixel_valid (i_pixel_valid),
        .i_sof         (i_sof),
        .o_pixel_ack   (o_pixel_ack),
        .o_pixel_1     (o_pixel_1),
        .o_pixel_2     (o_pixel_2),
        .o_pixel_3     (o_pixel_3),
        .o_pixel_valid (o_pixel_valid),
        .i_pixel_ack   (i_pixel_ack)
    );

    int          n_vec = 0;
    int          n_err = 0;
    // Image model: every accepted pixel stored at its (row, col) in the frame.
    logic [7:0]  img [32][LW];
    int          m_row = 0;
    int          m_col = 0;
    logic [23:0] q [$];
    logic [23:0] prev_out = '0;
    logic        prev_hold = 1'b0;
    logic        pend = 1'b0;

    function automatic logic [23:0] col_out();
        return {o_pixel_1, o_pixel_2, o_pixel_3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] p, input logic sof);
        int n = 0;
        i_pixel       = p;
        i_sof         = sof;
        i_pixel_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (o_pixel_ack) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        i_pixel_valid = 1'b0;
        i_sof         = 1'b0;
    endtask

    task automatic px(input int base, input int row, input int col, input logic sof);
        send(8'(base + 10 * row + col), sof);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            chk("ack_rule", {31'd0, o_pixel_ack}, {31'd0, (!o_pixel_valid || i_pixel_ack)});
            if (!i_rst_n) begin
                m_row = 0;
                m_col = 0;
                q.delete();
                prev_hold = 1'b0;
                pend = 1'b0;
            end else begin
                if (prev_hold)
                    chk("hold", {7'd0, o_pixel_valid, col_out()}, {7'd0, 1'b1, prev_out});
                if (pend)
                    chk("valid_latency", {31'd0, o_pixel_valid}, 32'd1);
                pend = 1'b0;
                if (o_pixel_valid && i_pixel_ack) begin
                    if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                    else               chk("column", {8'd0, col_out()}, {8'd0, q.pop_front()});
                end
                prev_hold = o_pixel_valid && !i_pixel_ack;
                prev_out  = col_out();
                if (i_pixel_valid && o_pixel_ack) begin
                    if (i_sof) begin
                        m_row = 0;
                        m_col = 0;
                    end
                    img[m_row][m_col] = i_pixel;
                    if (m_row >= 2) begin
                        q.push_back({img[m_row-2][m_col], img[m_row-1][m_col], i_pixel});
                        pend = 1'b1;
                    end
                    m_col++;
                    if (m_col == LW) begin
                        m_col = 0;
                        if (m_row < 31) m_row++;
                    end
                end
            end
        end
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_pixel       = 8'd0;
        i_pixel_valid = 1'b0;
        i_sof         = 1'b0;
        i_pixel_ack   = 1'b1;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, o_pixel_valid}, 32'd0);
        chk("reset_cols", {8'd0, col_out()}, 32'd0);
        chk("reset_ack", {31'd0, o_pixel_ack}, 32'd1);
        i_rst_n = 1'b1;

        // Prime two lines: nothing emitted, always ready.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < LW; c++) begin
                px(0, r, c, (r == 0 && c == 0));
                chk("prime_valid", {31'd0, o_pixel_valid}, 32'd0);
                chk("prime_ack", {31'd0, o_pixel_ack}, 32'd1);
            end

        for (int c = 0; c < LW; c++) begin
            px(0, 2, c, 1'b0);
            if (c == 0) chk("first_col", {8'd0, col_out()}, {8'd0, 8'd0, 8'd10, 8'd20});
            chk("stream_valid", {31'd0, o_pixel_valid}, 32'd1);
        end

        // Backpressure for three cycles while (3,13,23) is held.
        i_pixel_ack = 1'b0;
        fork
            px(0, 3, 0, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ack", {31'd0, o_pixel_ack}, 32'd0);
                    chk("bp_frozen", {8'd0, col_out()}, {8'd0, 8'd3, 8'd13, 8'd23});
                end
                @(posedge clk);
                #1;
                i_pixel_ack = 1'b1;
            end
        join
        chk("bp_next", {8'd0, col_out()}, {8'd0, 8'd10, 8'd20, 8'd30});
        for (int c = 1; c < LW; c++) px(0, 3, c, 1'b0);
        chk("row3_col3", {8'd0, col_out()}, {8'd0, 8'd13, 8'd23, 8'd33});

        // Mid-line start of frame: refill before the next column.
        px(0, 4, 0, 1'b0);
        px(0, 4, 1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            px(100, k / LW, k % LW, (k == 0));
            if (k < 8) chk("sof_refill_valid", {31'd0, o_pixel_valid}, 32'd0);
            else       chk("sof_refill_col", {8'd0, col_out()}, {8'd0, 8'd100, 8'd110, 8'd120});
        end
        px(100, 2, 1, 1'b0);
        px(100, 2, 2, 1'b0);

        // Asynchronous reset while a column is stalled.
        i_pixel_ack = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, o_pixel_valid}, 32'd0);
        chk("rst_mid_cols", {8'd0, col_out()}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        i_rst_n     = 1'b1;
        i_pixel_ack = 1'b1;
        for (int k = 0; k < 9; k++) begin
            px(200, k / LW, k % LW, 1'b0);
            if (k < 8) chk("rst_refill_valid", {31'd0, o_pixel_valid}, 32'd0);
            else       chk("rst_refill_col", {8'd0, col_out()}, {8'd0, 8'd200, 8'd210, 8'd220});
        end

        // Gapped input: one idle cycle after every pixel.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                px(0, r, c, (r == 0 && c == 0));
                if (r >= 2) chk("gap_pulse", {31'd0, o_pixel_valid}, 32'd1);
                if (r == 2 && c == 0) chk("gap_first", {8'd0, col_out()}, {8'd0, 8'd0, 8'd10, 8'd20});
                if (r == 3 && c == 3) chk("gap_last", {8'd0, col_out()}, {8'd0, 8'd13, 8'd23, 8'd33});
                @(posedge clk);
                #1;
                chk("gap_idle", {31'd0, o_pixel_valid}, 32'd0);
            end

        repeat (3) @(posedge clk);
        #1;
        chk("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
